// File: rtl/add_fp32_arbiter.sv
// Shares one fixed-latency add_fp32 pipeline among NUM_REQ requesters, returning results in issue order.
// Define ADD_FP32_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.

module add_fp32_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_rm,
  input  logic [32*NUM_REQ-1:0] req_src1,
  input  logic [32*NUM_REQ-1:0] req_src2,
  output logic                  fpu_en,
  output logic [2:0]            fpu_rm,
  output logic [31:0]           fpu_src1,
  output logic [31:0]           fpu_src2,
  input  logic [31:0]           fpu_result,
  input  logic                  fpu_nv,
  input  logic                  fpu_of,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_nv,
  output logic                  rsp_of,
  output logic                  busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [31:0]     result;
    logic            nv;
    logic            of;
    logic [ID_W-1:0] id;
  } rsp_entry_t;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic                credit_ok;
  logic                issue;
  logic [CNT_W-1:0]    credit_cnt;

  logic [LATENCY-1:0]  tag_vld_q;
  logic [ID_W-1:0]     tag_id_q [LATENCY];

  rsp_entry_t          fifo_mem [FIFO_DEPTH];
  rsp_entry_t          head;
  rsp_entry_t          wr_entry;
  logic                fifo_wr;
  logic                fifo_nonempty;
  logic                pop;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [INF_W-1:0]    inflight_q, inflight_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ADD_FP32_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    // Descending scan so the lowest valid index is the last (winning) assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(k);
      end
    end
  end
`else
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int idx;
    // NOTE: every output of this block gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Every accepted op already owns a FIFO slot, counting those leaving this cycle.
  always_comb begin
    credit_cnt = CNT_W'(occ_q) + CNT_W'(inflight_q) - CNT_W'(pop);
    credit_ok  = (credit_cnt < DEPTH_CNT);
  end

  assign issue = !reset && grant_found && credit_ok;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    fpu_en   = issue;
    fpu_rm   = '0;
    fpu_src1 = '0;
    fpu_src2 = '0;
    if (issue) begin
      fpu_rm   = req_rm[3*grant_id +: 3];
      fpu_src1 = req_src1[32*grant_id +: 32];
      fpu_src2 = req_src2[32*grant_id +: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: follows each op through the adder so its result finds its owner
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's pre-edge
      // value; blocking ones would ripple one op through all stages in a single clock.
      tag_vld_q[0] <= issue;
      for (int k = 1; k < LATENCY; k++) tag_vld_q[k] <= tag_vld_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_id_q[0] <= grant_id;
    for (int k = 1; k < LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
  end

  assign fifo_wr  = tag_vld_q[LATENCY-1];
  assign wr_entry = '{result: fpu_result, nv: fpu_nv, of: fpu_of, id: tag_id_q[LATENCY-1]};

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; occupancy decides which entries are live, and
  // leaving it unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= wr_entry;
  end

  assign head          = fifo_mem[rd_ptr_q];
  assign fifo_nonempty = !reset && (occ_q != '0);
  assign pop           = fifo_nonempty && rsp_ready[head.id];

  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_nv     = 1'b0;
    rsp_of     = 1'b0;
    if (fifo_nonempty) begin
      rsp_valid[head.id] = 1'b1;
      rsp_result         = head.result;
      rsp_nv             = head.nv;
      rsp_of             = head.of;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    occ_d      = occ_q + OCC_W'(fifo_wr) - OCC_W'(pop);
    inflight_d = inflight_q + INF_W'(issue) - INF_W'(fifo_wr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy = !reset && ((inflight_q != '0) || (occ_q != '0));

  // A writing op was counted against credit, so the FIFO cannot be full when it lands.
  always_ff @(posedge clock) begin
    if (!reset && fifo_wr) assert (occ_q != DEPTH_OCC);
  end

endmodule
